// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: reset/NOP constants, instruction field positions
// and the next-PC source selection used by the fetch stage.
package cpu_defs;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

    localparam int unsigned IMM_LSB  = 0;
    localparam int unsigned IMM_MSB  = 15;
    localparam int unsigned JIDX_MSB = 25;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_HOLD   = 2'd1,
        PC_BRANCH = 2'd2,
        PC_JUMP   = 2'd3
    } pc_sel_e;

    function automatic logic [31:0] jump_target(input logic [31:0]       pc4,
                                                input logic [JIDX_MSB:0] idx);
        return {pc4[31:28], idx, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_pc_next.sv
// Next-PC computation: sequential, branch and jump targets plus the
// redirect/stall priority mux feeding the PC register.
module pc_next_logic
    import cpu_defs::*;
(
    input  logic [31:0]       i_pc,
    input  logic [31:0]       i_if_id_pc4,
    input  logic              i_stall,
    input  logic              i_branch_taken,
    input  logic [31:0]       i_branch_offset,
    input  logic              i_jump,
    input  logic [JIDX_MSB:0] i_jump_index,
    output logic [31:0]       o_pc4,
    output logic [31:0]       o_next_pc,
    output pc_sel_e           o_sel
);

    logic [31:0] w_pc4;
    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;

    always_comb begin
        w_pc4    = i_pc + 32'd4;
        w_br_tgt = i_if_id_pc4 + {i_branch_offset[29:0], 2'b00};
        w_j_tgt  = jump_target(i_if_id_pc4, i_jump_index);
    end

    // Redirects beat stall: the stalled fetch slot is already wrong-path.
    always_comb begin
        o_sel     = PC_SEQ;
        o_next_pc = w_pc4;
        if (i_jump) begin
            o_sel     = PC_JUMP;
            o_next_pc = w_j_tgt;
        end else if (i_branch_taken) begin
            o_sel     = PC_BRANCH;
            o_next_pc = w_br_tgt;
        end else if (i_stall) begin
            o_sel     = PC_HOLD;
            o_next_pc = i_pc;
        end
    end

    assign o_pc4 = w_pc4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register and IF/ID pipeline register, fed by a
// combinational instruction memory and redirected by decode.
module fetch_stage
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [31:0]       branch_offset,
    input  logic              jump,
    input  logic [JIDX_MSB:0] jump_index,
    output logic [31:0]       imem_addr,
    input  logic [31:0]       imem_data,
    output logic [31:0]       if_id_instr,
    output logic [31:0]       if_id_pc4,
    output logic              if_id_valid,
    output logic [15:0]       imm16
);

    logic [31:0] r_pc;
    logic [31:0] r_if_id_instr;
    logic [31:0] r_if_id_pc4;
    logic        r_if_id_valid;

    logic [31:0] w_pc4;
    logic [31:0] w_next_pc;
    pc_sel_e     w_sel;

    pc_next_logic u_pc_next (
        .i_pc            (r_pc),
        .i_if_id_pc4     (r_if_id_pc4),
        .i_stall         (stall),
        .i_branch_taken  (branch_taken),
        .i_branch_offset (branch_offset),
        .i_jump          (jump),
        .i_jump_index    (jump_index),
        .o_pc4           (w_pc4),
        .o_next_pc       (w_next_pc),
        .o_sel           (w_sel)
    );

    // A flush replaces the instruction with a bubble; its pc4 is left as-is.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_pc4   <= '0;
            r_if_id_valid <= 1'b0;
        end else begin
            r_pc <= w_next_pc;
            unique case (w_sel)
                PC_JUMP, PC_BRANCH: begin
                    r_if_id_instr <= NOP_INSTR;
                    r_if_id_valid <= 1'b0;
                end
                PC_HOLD: begin
                    r_if_id_instr <= r_if_id_instr;
                    r_if_id_pc4   <= r_if_id_pc4;
                    r_if_id_valid <= r_if_id_valid;
                end
                default: begin
                    r_if_id_instr <= imem_data;
                    r_if_id_pc4   <= w_pc4;
                    r_if_id_valid <= 1'b1;
                end
            endcase
        end
    end

    assign imem_addr   = r_pc;
    assign if_id_instr = r_if_id_instr;
    assign if_id_pc4   = r_if_id_pc4;
    assign if_id_valid = r_if_id_valid;
    assign imm16       = r_if_id_instr[IMM_MSB:IMM_LSB];

endmodule
